zigzag_runlevel_4x4: RTL and testbench

Converts each quantized 4x4 luma residual block from the quantizer into the symbol stream consumed by the CAVLC entropy coder. The block reorders coefficients in zigzag order, then computes TotalCoeff, TrailingOnes and TotalZeros. It then emits the nonzero levels in reverse zigzag order (highest frequency first), each with its run_before. It sits directly downstream of the quantizer and upstream of the CAVLC encoder.

---
 rtl/zigzag_runlevel_4x4.sv | 157 +++++++++++++++
 tb/tb_zigzag_runlevel_4x4.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_runlevel_4x4.sv
// Zigzag reorder of a quantized 4x4 block, CAVLC statistics (TotalCoeff,
// TrailingOnes, TotalZeros) and reverse-order (level, run_before) beats.
module zigzag_runlevel_4x4 #(
    parameter int BIT_LENGTH = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BIT_LENGTH:0] quantized [16],
    output logic                       stats_valid,
    output logic [4:0]                 total_coeff,
    output logic [1:0]                 trailing_ones,
    output logic [3:0]                 total_zeros,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BIT_LENGTH:0] out_level,
    output logic [3:0]                 out_run,
    output logic                       out_last,
    output logic [1:0]                 dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a presented beat (out_valid) and its payload stay stable until accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, ANALYZE = 2'd1, STREAM = 2'd2} state_t;

    localparam logic [3:0] ZZ_MAP [16] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                                           4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};

    state_t                    state_q;
    logic signed [BIT_LENGTH:0] zz_q  [16];
    logic signed [BIT_LENGTH:0] lev_q [16];
    logic [3:0]                run_q [16];
    logic [3:0]                k_q;
    logic [4:0]                n_q, n_d;
    logic [3:0]                zc_q, zc_d;
    logic [3:0]                tz_q, tz_d;
    logic [1:0]                t1_q, t1_d;
    logic                      t1_open_q, t1_open_d;
    logic [3:0]                beat_q;
    logic                      stats_valid_q;
    logic [4:0]                total_coeff_q;
    logic [1:0]                trailing_ones_q;
    logic [3:0]                total_zeros_q;

    logic signed [BIT_LENGTH:0] cur;
    logic                      cur_nz, cur_one;
    logic [4:0]                n_qm1, n_dm1;

    // One ANALYZE step for position k_q, scanning from high frequency down.
    always_comb begin
        cur       = zz_q[k_q];
        cur_nz    = (cur != '0);
        cur_one   = (cur == {{BIT_LENGTH{1'b0}}, 1'b1}) || (cur == {(BIT_LENGTH+1){1'b1}});
        n_d       = n_q;
        zc_d      = zc_q;
        tz_d      = tz_q;
        t1_d      = t1_q;
        t1_open_d = t1_open_q;
        if (cur_nz) begin
            zc_d = 4'd0;
            n_d  = n_q + 5'd1;
            if (t1_open_q && cur_one && (t1_q != 2'd3)) begin
                t1_d = t1_q + 2'd1;
            end else begin
                t1_open_d = 1'b0;
            end
        end else if (n_q != 5'd0) begin
            zc_d = zc_q + 4'd1;
            tz_d = tz_q + 4'd1;
        end
        n_qm1 = n_q - 5'd1;
        n_dm1 = n_d - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            stats_valid_q   <= 1'b0;
            total_coeff_q   <= 5'd0;
            trailing_ones_q <= 2'd0;
            total_zeros_q   <= 4'd0;
            beat_q          <= 4'd0;
            k_q             <= 4'd0;
            n_q             <= 5'd0;
            zc_q            <= 4'd0;
            tz_q            <= 4'd0;
            t1_q            <= 2'd0;
            t1_open_q       <= 1'b0;
        end else begin
            stats_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) begin
                            zz_q[k] <= quantized[ZZ_MAP[k]];
                        end
                        k_q       <= 4'd15;
                        n_q       <= 5'd0;
                        zc_q      <= 4'd0;
                        tz_q      <= 4'd0;
                        t1_q      <= 2'd0;
                        t1_open_q <= 1'b1;
                        state_q   <= ANALYZE;
                    end
                end
                ANALYZE: begin
                    n_q       <= n_d;
                    zc_q      <= zc_d;
                    tz_q      <= tz_d;
                    t1_q      <= t1_d;
                    t1_open_q <= t1_open_d;
                    k_q       <= k_q - 4'd1;
                    if (cur_nz) begin
                        lev_q[n_q[3:0]] <= cur;
                        if (n_q != 5'd0) begin
                            run_q[n_qm1[3:0]] <= zc_q;
                        end
                    end
                    if (k_q == 4'd0) begin
                        // The lowest-frequency level's run covers all zeros below it.
                        if (n_d != 5'd0) begin
                            run_q[n_dm1[3:0]] <= zc_d;
                        end
                        total_coeff_q   <= n_d;
                        trailing_ones_q <= t1_d;
                        total_zeros_q   <= tz_d;
                        stats_valid_q   <= 1'b1;
                        beat_q          <= 4'd0;
                        state_q         <= (n_d == 5'd0) ? IDLE : STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == IDLE) && !reset;
    assign out_valid     = (state_q == STREAM);
    assign out_level     = out_valid ? lev_q[beat_q] : '0;
    assign out_run       = out_valid ? run_q[beat_q] : 4'd0;
    assign out_last      = out_valid && ({1'b0, beat_q} == (total_coeff_q - 5'd1));
    assign stats_valid   = stats_valid_q;
    assign total_coeff   = total_coeff_q;
    assign trailing_ones = trailing_ones_q;
    assign total_zeros   = total_zeros_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_zigzag_runlevel_4x4.sv
// Bench for zigzag_runlevel_4x4: directed and random blocks compared every
// cycle against a list-based model of the zigzag/run-level rules.
module tb_zigzag_runlevel_4x4;
    localparam int BL = 15;
    typedef logic signed [BL:0] blk_t [16];
    localparam int ZZ_MAP [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    blk_t              quantized;
    logic              in_ready, stats_valid, out_valid, out_last;
    logic [4:0]        total_coeff;
    logic [1:0]        trailing_ones;
    logic [3:0]        total_zeros;
    logic signed [BL:0] out_level;
    logic [3:0]        out_run;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    zigzag_runlevel_4x4 #(.BIT_LENGTH(BL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .quantized(quantized), .stats_valid(stats_valid), .total_coeff(total_coeff),
        .trailing_ones(trailing_ones), .total_zeros(total_zeros), .out_valid(out_valid),
        .out_ready(out_ready), .out_level(out_level), .out_run(out_run),
        .out_last(out_last), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: list the nonzero zigzag positions from high to low frequency.
    task automatic model(input blk_t b, output int tc, output int t1, output int tz,
                         output int lv[16], output int rn[16]);
        int zz[16];
        int pos[16];
        int hi;
        tc = 0;
        t1 = 0;
        hi = -1;
        for (int k = 0; k < 16; k++) begin
            zz[k] = b[ZZ_MAP[k]];
            lv[k] = 0;
            rn[k] = 0;
            pos[k] = 0;
        end
        for (int k = 15; k >= 0; k--) begin
            if (zz[k] != 0) begin
                if (hi < 0) hi = k;
                pos[tc] = k;
                lv[tc] = zz[k];
                tc++;
            end
        end
        tz = (hi < 0) ? 0 : hi + 1 - tc;
        for (int i = 0; i < tc; i++) begin
            rn[i] = (i == tc - 1) ? pos[i] : pos[i] - pos[i + 1] - 1;
        end
        for (int i = 0; i < tc && i < 3; i++) begin
            if (lv[i] == 1 || lv[i] == -1) t1++;
            else break;
        end
    endtask

    function automatic blk_t from_zz(input int zz[16]);
        blk_t r;
        for (int k = 0; k < 16; k++) r[ZZ_MAP[k]] = 16'(zz[k]);
        return r;
    endfunction

    function automatic blk_t rand_block();
        blk_t r;
        int dens, sel, mag;
        dens = int'($urandom_range(0, 16));
        for (int k = 0; k < 16; k++) begin
            r[k] = 16'sd0;
            if (int'($urandom_range(0, 15)) < dens) begin
                sel = int'($urandom_range(0, 9));
                mag = int'($urandom_range(2, 20));
                if (sel < 6) r[k] = ($urandom_range(0, 1) != 0) ? 16'sd1 : -16'sd1;
                else if (sel < 8) r[k] = 16'(($urandom_range(0, 1) != 0) ? mag : -mag);
                else if (sel == 8) r[k] = 16'sd32767;
                else r[k] = 16'h8000;
            end
        end
        return r;
    endfunction

    // Scoreboard state
    logic [20:0] exp_q[$];
    int  exp_cyc = -1;
    bit  streaming = 1'b0;
    int  pend_tc, pend_t1, pend_tz;
    int  held_tc = 0, held_t1 = 0, held_tz = 0;
    int  hs_count = 0;
    int  acc_last = 0, acc_prev = 0;

    always @(negedge clk) begin
        logic [20:0] b;
        bit stats_now, busy;
        int tc, t1, tz;
        int lv[16];
        int rn[16];
        if (reset) begin
            chk("in_ready_in_reset", in_ready, 0);
            exp_q.delete();
            streaming = 1'b0;
            exp_cyc = -1;
            held_tc = 0;
            held_t1 = 0;
            held_tz = 0;
        end else begin
            stats_now = (exp_cyc == cyc);
            if (stats_now) begin
                held_tc = pend_tc;
                held_t1 = pend_t1;
                held_tz = pend_tz;
                streaming = (pend_tc != 0);
                exp_cyc = -1;
            end
            busy = (exp_cyc >= 0) || streaming;
            chk("in_ready", in_ready, !busy);
            chk("stats_valid", stats_valid, stats_now);
            chk("total_coeff", total_coeff, held_tc);
            chk("trailing_ones", trailing_ones, held_t1);
            chk("total_zeros", total_zeros, held_tz);
            chk("out_valid", out_valid, streaming);
            if (streaming && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_expected", 1, 0);
                end else begin
                    b = exp_q[0];
                    chk("out_level", out_level, $signed(b[20:5]));
                    chk("out_run", out_run, b[4:1]);
                    chk("out_last", out_last, b[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (b[0]) streaming = 1'b0;
                    end
                end
            end
            if (in_valid && !busy) begin
                model(quantized, tc, t1, tz, lv, rn);
                for (int i = 0; i < tc; i++) begin
                    exp_q.push_back({16'(lv[i]), 4'(rn[i]), (i == tc - 1)});
                end
                pend_tc = tc;
                pend_t1 = t1;
                pend_tz = tz;
                exp_cyc = cyc + 17;
                hs_count = 0;
                acc_prev = acc_last;
                acc_last = cyc;
            end
        end
    end

    task automatic send_block(input blk_t b, input int extra);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        quantized = b;
        in_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (extra > 0) begin
            quantized = rand_block();
            repeat (extra) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: three stall cycles on beat 1
    task automatic drain(input int mode);
        int stalls;
        bit done;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (exp_cyc < 0 && !streaming) begin
                done = 1'b1;
                break;
            end
            if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && hs_count == 1 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else out_ready = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        if (mode == 2) chk("stall_applied", stalls, 3);
        out_ready = 1'b1;
    endtask

    initial begin
        int tc, t1, tz;
        int lv[16];
        int rn[16];
        int zz[16];
        blk_t b_zero, b_t2, b_t4, b_t5;
        for (int k = 0; k < 16; k++) b_zero[k] = 16'sd0;
        b_t2 = b_zero;
        b_t2[1] = 16'sd3;
        b_t2[2] = -16'sd1;
        b_t2[5] = -16'sd1;
        b_t2[6] = 16'sd1;
        b_t2[8] = 16'sd1;
        for (int k = 0; k < 16; k++) zz[k] = 0;
        zz[15] = -2; zz[14] = 1; zz[13] = 1; zz[12] = 1;
        b_t4 = from_zz(zz);
        for (int k = 0; k < 16; k++) zz[k] = 1;
        zz[0] = -32768;
        b_t5 = from_zz(zz);
        quantized = b_zero;

        // Hand-computed values pinning the model
        model(b_t2, tc, t1, tz, lv, rn);
        chk("pin_t2_tc", tc, 5);
        chk("pin_t2_t1", t1, 3);
        chk("pin_t2_tz", tz, 3);
        chk("pin_t2_lv0", lv[0], 1);  chk("pin_t2_rn0", rn[0], 1);
        chk("pin_t2_lv1", lv[1], -1); chk("pin_t2_rn1", rn[1], 0);
        chk("pin_t2_lv2", lv[2], -1); chk("pin_t2_rn2", rn[2], 0);
        chk("pin_t2_lv3", lv[3], 1);  chk("pin_t2_rn3", rn[3], 1);
        chk("pin_t2_lv4", lv[4], 3);  chk("pin_t2_rn4", rn[4], 1);
        model(b_t4, tc, t1, tz, lv, rn);
        chk("pin_t4_tc", tc, 4);
        chk("pin_t4_t1", t1, 0);
        chk("pin_t4_tz", tz, 12);
        chk("pin_t4_lv0", lv[0], -2);
        chk("pin_t4_rn3", rn[3], 12);
        model(b_t5, tc, t1, tz, lv, rn);
        chk("pin_t5_tc", tc, 16);
        chk("pin_t5_t1", t1, 3);
        chk("pin_t5_tz", tz, 0);
        chk("pin_t5_lv15", lv[15], -32768);
        chk("pin_t5_rn15", rn[15], 0);
        model(b_zero, tc, t1, tz, lv, rn);
        chk("pin_zero_tc", tc, 0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Empty block followed immediately by a second block
        send_block(b_zero, 0);
        send_block(b_t2, 0);
        chk("b2b_accept_gap", acc_last - acc_prev, 17);
        drain(0);

        send_block(b_t2, 0);
        drain(2);
        send_block(b_t4, 2);
        drain(1);
        send_block(b_t5, 0);
        drain(0);

        // Reset while beat 1 is presented
        send_block(b_t2, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (hs_count >= 1) break;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", out_valid, 0);
        chk("post_reset_in_ready", in_ready, 1);
        send_block(b_t4, 0);
        drain(0);

        // Reset mid-ANALYZE
        send_block(b_t5, 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send_block(b_t5, 0);
        drain(1);

        for (int n = 0; n < 40; n++) begin
            send_block(rand_block(), int'($urandom_range(0, 3)));
            drain(int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
